con_seq: RTL and testbench
==========================

# con_seq

Parametrised multi-cycle control sequencer for the model CPU, the successor to the single-bit-`sm` combinational control decoder. It takes one-hot opcode strobes from the instruction decoder, the instruction register and the Z/C flags. It runs an explicit IDLE/FETCH/EXEC/MEM/HALT state machine with a `mem_ack` handshake to RAM and drives all datapath control strobes (PC, IR, register file, ALU, shifter, flags, I/O, memory mux). It also keeps a retired-instruction counter.

## Interface
- `IR_W`, 8, instruction register width
- `RA_W`, 2, register address field width; `IR_W >= 2*RA_W + ALU_S_W`
- `ALU_S_W`, 4, ALU function select width
- `CNT_W`, 16, retired-instruction counter width
- `clk`  in  1  clock; all state updates on the rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `run`  in  1  level; allows leaving IDLE and continuing past instruction boundaries
- `mova, movb, movc, add, sub, and1, not1, rsr, rsl, jmp, jz, jc, in1, out1, nop, halt`  in  1 each  one-hot decoded opcode strobes, sampled in EXEC
- `ir`  in  IR_W  instruction register contents
- `z`, `c`  in  1 each  zero and carry flags, sampled in EXEC
- `mem_ack`  in  1  RAM completed the current read/write this cycle
- `reg_ra`, `reg_wa`  out  RA_W each  `ir[RA_W-1:0]` and `ir[2*RA_W-1:RA_W]`
- `alu_s`  out  ALU_S_W  `ir[IR_W-1 -: ALU_S_W]`
- `madd`  out  2  memory address source: 00 PC, 01 register (movc), 10 register (movb)
- `pc_ld`, `pc_inc`, `ir_ld`, `ram_dl` (read), `ram_xl` (write), `alu_m`, `shi_fbus`, `shi_flbus`, `shi_frbus`, `cf_en`, `zf_en`, `in_en`, `out_en`  out  1 each  active-high
- `reg_we`  out  1  register-file write, active-low
- `halted`  out  1  high in HALT
- `illegal`  out  1  one-cycle pulse: EXEC saw zero or more than one strobe
- `instr_cnt`  out  CNT_W  retired instructions, wraps

## Operation
- Reset: state IDLE. All outputs 0 except `reg_we`=1. `instr_cnt`=0. Field outputs `reg_ra`, `reg_wa` and `alu_s` are combinational from `ir` in every state.
- IDLE → FETCH when `run`=1. Otherwise stay in IDLE.
- FETCH: `madd`=00 and `ram_dl`=1, held until ack. On the `mem_ack` cycle, `ir_ld`=1 and `pc_inc`=1, then go to EXEC.
- EXEC, single-cycle classes, then go to retire:
  - `mova`, `add`, `sub`, `and1`, `not1`, `rsr`, `rsl`, `in1`: `reg_we`=0.
  - `alu_m` = `add`|`sub`|`and1`|`not1`.
  - `shi_fbus` = `mova`|`add`|`sub`|`and1`|`not1`|`out1`.
  - `shi_flbus` = `rsl`; `shi_frbus` = `rsr`.
  - `cf_en` = `add`|`sub`|`rsr`|`rsl`; `zf_en` = `add`|`sub`.
  - `in_en` = `in1`; `out_en` = `out1`.
  - `nop`: no strobes.
  - `jz` with `z`=0, or `jc` with `c`=0: `pc_inc`=1 (skip the address byte).
- EXEC → MEM for memory classes: `movb`, `movc`, `jmp`, taken `jz`, taken `jc`.
- MEM, per class:
  - `movc`: `madd`=01, `ram_dl`=1.
  - `movb`: `madd`=10, `ram_xl`=1, `shi_fbus`=1.
  - Jumps: `madd`=00, `ram_dl`=1.
  - These signals are held stable while `mem_ack`=0.
  - On the ack cycle only: `movc` asserts `reg_we`=0; jumps assert `pc_ld`=1. Then go to retire.
- EXEC with `halt`: go to HALT, no strobes. `halt` is not counted. HALT is left only by reset.
- Illegal (zero or multiple strobes): pulse `illegal`, execute as `nop`, count it.
- Retire: `instr_cnt` += 1 (mod 2^CNT_W). Next state is FETCH if `run`=1, else IDLE.

## Timing
- Register/ALU instruction: FETCH (1 + fetch wait cycles) + 1 EXEC cycle. With zero-wait memory, 2 cycles.
- Memory or jump instruction: FETCH + EXEC + MEM (1 + wait cycles). With zero-wait memory, 3 cycles.
- Commit strobes (`ir_ld`, `pc_inc`, `pc_ld`, `reg_we` low, `cf_en`, `zf_en`) last exactly one cycle per instruction.
- `z` and `c` are sampled only in the EXEC cycle. Flag changes during MEM are ignored.
- `run` dropping mid-instruction has no effect until retire.
- `rst_n` low in any state forces IDLE and the reset output values immediately, without waiting for `clk`. Any pending `mem_ack` is dropped.
- `instr_cnt` at all ones wraps to 0 on the next retire.

## Structure
- Package `con_seq_pkg`:
  - state enum: IDLE, FETCH, EXEC, MEM, HALT
  - `madd` constants `MADD_PC`, `MADD_MOVC`, `MADD_MOVB`
  - class enum for the latched memory class: LOAD, STORE, JUMP
- One combinational sub-module `con_seq_out`: state + latched class + strobes + flags + `mem_ack` → control outputs.
- The top level holds the state register, class latch and counter.

## Test plan
- Reset, then `run`=1 and `add` with zero-wait ack: FETCH then EXEC, 2 cycles. EXEC shows `reg_we`=0, `alu_m`=1, `cf_en`=`zf_en`=1. `instr_cnt`=1.
- `movc` with `mem_ack` delayed 3 cycles: `madd`=01 and `ram_dl`=1 held 4 cycles. `reg_we`=0 only in the ack cycle.
- `jz` with `z`=0: single EXEC `pc_inc`=1, no MEM. `jz` with `z`=1: MEM with `pc_ld`=1 on ack.
- EXEC with both `add` and `sub` high: `illegal` pulses once, no strobes asserted, `instr_cnt` increments.
- `halt`: `halted`=1 and stays with `run`=1 for 10 cycles. Asserting `rst_n`=0 mid-wait in MEM returns to IDLE asynchronously with `instr_cnt`=0.
- Preload 2^CNT_W-1 instructions, retire one more: `instr_cnt` reads 0.

Source files
------------

// File: rtl/con_seq_pkg.sv
// Shared types for the con_seq multi-cycle control sequencer: FSM states,
// latched memory-class encoding, memory-address mux codes and the opcode strobe bundle.
package con_seq_pkg;

   typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, HALT} state_t;

   typedef enum logic [1:0] {LOAD, STORE, JUMP} mclass_t;

   localparam logic [1:0] MADD_PC   = 2'b00;
   localparam logic [1:0] MADD_MOVC = 2'b01;
   localparam logic [1:0] MADD_MOVB = 2'b10;

   typedef struct packed {
      logic mova;
      logic movb;
      logic movc;
      logic add;
      logic sub;
      logic and1;
      logic not1;
      logic rsr;
      logic rsl;
      logic jmp;
      logic jz;
      logic jc;
      logic in1;
      logic out1;
      logic nop;
      logic halt;
   } op_t;

   // Instructions that need a second RAM access (data or jump target) after EXEC.
   function automatic logic needs_mem(input op_t op, input logic z, input logic c);
      return op.movb | op.movc | op.jmp | (op.jz & z) | (op.jc & c);
   endfunction

   function automatic mclass_t mem_class(input op_t op);
      if (op.movc)      return LOAD;
      else if (op.movb) return STORE;
      else              return JUMP;
   endfunction

endpackage

// File: rtl/con_seq_out.sv
// Combinational control-strobe decode for con_seq: maps state, latched memory
// class, opcode strobes, flags and the RAM handshake onto the datapath controls.
module con_seq_out
   import con_seq_pkg::*;
(
   input  state_t     i_state,
   input  mclass_t    i_mclass,
   input  op_t        i_op,
   input  logic       i_legal,
   input  logic       i_z,
   input  logic       i_c,
   input  logic       i_mem_ack,
   output logic [1:0] o_madd,
   output logic       o_pc_ld,
   output logic       o_pc_inc,
   output logic       o_ir_ld,
   output logic       o_ram_dl,
   output logic       o_ram_xl,
   output logic       o_alu_m,
   output logic       o_shi_fbus,
   output logic       o_shi_flbus,
   output logic       o_shi_frbus,
   output logic       o_cf_en,
   output logic       o_zf_en,
   output logic       o_in_en,
   output logic       o_out_en,
   output logic       o_reg_we,
   output logic       o_halted,
   output logic       o_illegal
);

   always_comb begin
      o_madd      = MADD_PC;
      o_pc_ld     = 1'b0;
      o_pc_inc    = 1'b0;
      o_ir_ld     = 1'b0;
      o_ram_dl    = 1'b0;
      o_ram_xl    = 1'b0;
      o_alu_m     = 1'b0;
      o_shi_fbus  = 1'b0;
      o_shi_flbus = 1'b0;
      o_shi_frbus = 1'b0;
      o_cf_en     = 1'b0;
      o_zf_en     = 1'b0;
      o_in_en     = 1'b0;
      o_out_en    = 1'b0;
      o_reg_we    = 1'b1;
      o_halted    = 1'b0;
      o_illegal   = 1'b0;
      case (i_state)
         FETCH: begin
            o_ram_dl = 1'b1;
            o_ir_ld  = i_mem_ack;
            o_pc_inc = i_mem_ack;
         end
         EXEC: begin
            o_illegal = ~i_legal;
            // Illegal decodes fall through as nop: every strobe stays at its default.
            if (i_legal && !(i_op.nop || i_op.halt)) begin
               o_reg_we    = ~(i_op.mova | i_op.add | i_op.sub | i_op.and1 |
                               i_op.not1 | i_op.rsr | i_op.rsl | i_op.in1);
               o_alu_m     = i_op.add | i_op.sub | i_op.and1 | i_op.not1;
               o_shi_fbus  = i_op.mova | i_op.add | i_op.sub | i_op.and1 |
                             i_op.not1 | i_op.out1;
               o_shi_flbus = i_op.rsl;
               o_shi_frbus = i_op.rsr;
               o_cf_en     = i_op.add | i_op.sub | i_op.rsr | i_op.rsl;
               o_zf_en     = i_op.add | i_op.sub;
               o_in_en     = i_op.in1;
               o_out_en    = i_op.out1;
               o_pc_inc    = (i_op.jz & ~i_z) | (i_op.jc & ~i_c);
            end
         end
         MEM: begin
            case (i_mclass)
               LOAD: begin
                  o_madd   = MADD_MOVC;
                  o_ram_dl = 1'b1;
                  o_reg_we = ~i_mem_ack;
               end
               STORE: begin
                  o_madd     = MADD_MOVB;
                  o_ram_xl   = 1'b1;
                  o_shi_fbus = 1'b1;
               end
               default: begin
                  o_ram_dl = 1'b1;
                  o_pc_ld  = i_mem_ack;
               end
            endcase
         end
         HALT: o_halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/con_seq.sv
// Multi-cycle control sequencer for the model CPU: IDLE/FETCH/EXEC/MEM/HALT
// state machine with a RAM handshake, latched memory class and retired-instruction counter.
module con_seq
   import con_seq_pkg::*;
#(
   parameter int IR_W    = 8,
   parameter int RA_W    = 2,
   parameter int ALU_S_W = 4,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               run,
   input  logic               mova,
   input  logic               movb,
   input  logic               movc,
   input  logic               add,
   input  logic               sub,
   input  logic               and1,
   input  logic               not1,
   input  logic               rsr,
   input  logic               rsl,
   input  logic               jmp,
   input  logic               jz,
   input  logic               jc,
   input  logic               in1,
   input  logic               out1,
   input  logic               nop,
   input  logic               halt,
   input  logic [IR_W-1:0]    ir,
   input  logic               z,
   input  logic               c,
   input  logic               mem_ack,
   output logic [RA_W-1:0]    reg_ra,
   output logic [RA_W-1:0]    reg_wa,
   output logic [ALU_S_W-1:0] alu_s,
   output logic [1:0]         madd,
   output logic               pc_ld,
   output logic               pc_inc,
   output logic               ir_ld,
   output logic               ram_dl,
   output logic               ram_xl,
   output logic               alu_m,
   output logic               shi_fbus,
   output logic               shi_flbus,
   output logic               shi_frbus,
   output logic               cf_en,
   output logic               zf_en,
   output logic               in_en,
   output logic               out_en,
   output logic               reg_we,
   output logic               halted,
   output logic               illegal,
   output logic [CNT_W-1:0]   instr_cnt
);

   state_t           r_state;
   state_t           w_next;
   mclass_t          r_mclass;
   logic [CNT_W-1:0] r_instr_cnt;
   op_t              w_op;
   logic             w_legal;
   logic             w_mem;
   logic             w_retire;

   assign w_op    = '{mova: mova, movb: movb, movc: movc, add: add, sub: sub,
                      and1: and1, not1: not1, rsr: rsr, rsl: rsl, jmp: jmp,
                      jz: jz, jc: jc, in1: in1, out1: out1, nop: nop, halt: halt};
   assign w_legal = $onehot(w_op);
   assign w_mem   = w_legal && needs_mem(w_op, z, c);

   assign reg_ra    = ir[RA_W-1:0];
   assign reg_wa    = ir[2*RA_W-1:RA_W];
   assign alu_s     = ir[IR_W-1 -: ALU_S_W];
   assign instr_cnt = r_instr_cnt;

   always_comb begin
      w_next   = r_state;
      w_retire = 1'b0;
      case (r_state)
         IDLE:  if (run) w_next = FETCH;
         FETCH: if (mem_ack) w_next = EXEC;
         EXEC: begin
            if (w_legal && w_op.halt) w_next = HALT;
            else if (w_mem)           w_next = MEM;
            else                      w_retire = 1'b1;
         end
         MEM:   if (mem_ack) w_retire = 1'b1;
         HALT:  w_next = HALT;
         default: w_next = IDLE;
      endcase
      // run is only consulted at the instruction boundary.
      if (w_retire) w_next = run ? FETCH : IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_mclass    <= LOAD;
         r_instr_cnt <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == EXEC) r_mclass <= mem_class(w_op);
         if (w_retire) r_instr_cnt <= r_instr_cnt + CNT_W'(1);
      end
   end

   con_seq_out u_out (
      .i_state     (r_state),
      .i_mclass    (r_mclass),
      .i_op        (w_op),
      .i_legal     (w_legal),
      .i_z         (z),
      .i_c         (c),
      .i_mem_ack   (mem_ack),
      .o_madd      (madd),
      .o_pc_ld     (pc_ld),
      .o_pc_inc    (pc_inc),
      .o_ir_ld     (ir_ld),
      .o_ram_dl    (ram_dl),
      .o_ram_xl    (ram_xl),
      .o_alu_m     (alu_m),
      .o_shi_fbus  (shi_fbus),
      .o_shi_flbus (shi_flbus),
      .o_shi_frbus (shi_frbus),
      .o_cf_en     (cf_en),
      .o_zf_en     (zf_en),
      .o_in_en     (in_en),
      .o_out_en    (out_en),
      .o_reg_we    (reg_we),
      .o_halted    (halted),
      .o_illegal   (illegal)
   );

endmodule

// File: tb/tb_con_seq.sv
// Scoreboard bench for con_seq: an instruction-level model predicts per-instruction
// strobe activity and cycle counts; a monitor summarises each instruction as it retires.
module tb_con_seq;
   localparam int CNT_W = 6;
   localparam int OP_MOVA = 0, OP_MOVB = 1, OP_MOVC = 2, OP_ADD = 3, OP_SUB = 4,
                  OP_AND = 5, OP_NOT = 6, OP_RSR = 7, OP_RSL = 8, OP_JMP = 9,
                  OP_JZ = 10, OP_JC = 11, OP_IN = 12, OP_OUT = 13, OP_NOP = 14,
                  OP_HALT = 15;

   typedef struct {
      int         cycles;
      logic [8:0] mask;   // {ram_xl,out_en,in_en,zf_en,cf_en,shi_frbus,shi_flbus,shi_fbus,alu_m}
      int         we_low;
      int         pc_inc;
      int         pc_ld;
      int         ir_ld;
      int         illegal;
      int         m01;
      int         m10;
      int         cnt;
      bit         mem;
   } exp_t;

   logic clk = 1'b0, rst_n = 1'b0, run = 1'b0, z = 1'b0, c = 1'b0, mem_ack = 1'b0;
   logic [15:0] ops = '0;
   logic [7:0]  ir = '0;
   logic [1:0]  reg_ra, reg_wa, madd;
   logic [3:0]  alu_s;
   logic pc_ld, pc_inc, ir_ld, ram_dl, ram_xl, alu_m, shi_fbus, shi_flbus, shi_frbus;
   logic cf_en, zf_en, in_en, out_en, reg_we, halted, illegal;
   logic [CNT_W-1:0] instr_cnt;

   exp_t exp_q[$];
   int   n_vec = 0, n_cmp = 0, n_fail = 0, m_cnt = 0;

   always #5 clk = ~clk;

   con_seq #(.IR_W(8), .RA_W(2), .ALU_S_W(4), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .run(run),
      .mova(ops[OP_MOVA]), .movb(ops[OP_MOVB]), .movc(ops[OP_MOVC]), .add(ops[OP_ADD]),
      .sub(ops[OP_SUB]), .and1(ops[OP_AND]), .not1(ops[OP_NOT]), .rsr(ops[OP_RSR]),
      .rsl(ops[OP_RSL]), .jmp(ops[OP_JMP]), .jz(ops[OP_JZ]), .jc(ops[OP_JC]),
      .in1(ops[OP_IN]), .out1(ops[OP_OUT]), .nop(ops[OP_NOP]), .halt(ops[OP_HALT]),
      .ir(ir), .z(z), .c(c), .mem_ack(mem_ack),
      .reg_ra(reg_ra), .reg_wa(reg_wa), .alu_s(alu_s), .madd(madd),
      .pc_ld(pc_ld), .pc_inc(pc_inc), .ir_ld(ir_ld), .ram_dl(ram_dl), .ram_xl(ram_xl),
      .alu_m(alu_m), .shi_fbus(shi_fbus), .shi_flbus(shi_flbus), .shi_frbus(shi_frbus),
      .cf_en(cf_en), .zf_en(zf_en), .in_en(in_en), .out_en(out_en),
      .reg_we(reg_we), .halted(halted), .illegal(illegal), .instr_cnt(instr_cnt)
   );

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Instruction-level reference: what one instruction should do in total.
   function automatic exp_t model(input logic [15:0] o, input logic zz, input logic cc,
                                  input int fw, input int mw);
      exp_t e;
      bit   jt;
      e = '{cycles: 2 + fw, mask: '0, we_low: 0, pc_inc: 1, pc_ld: 0, ir_ld: 1,
            illegal: 0, m01: 0, m10: 0, cnt: 0, mem: 1'b0};
      if ($countones(o) != 1) begin
         e.illegal = 1;
         return e;
      end
      jt = o[OP_JMP] | (o[OP_JZ] & zz) | (o[OP_JC] & cc);
      e.mem     = jt | o[OP_MOVB] | o[OP_MOVC];
      e.mask[0] = o[OP_ADD] | o[OP_SUB] | o[OP_AND] | o[OP_NOT];
      e.mask[1] = o[OP_MOVA] | o[OP_ADD] | o[OP_SUB] | o[OP_AND] | o[OP_NOT] |
                  o[OP_OUT] | o[OP_MOVB];
      e.mask[2] = o[OP_RSL];
      e.mask[3] = o[OP_RSR];
      e.mask[4] = o[OP_ADD] | o[OP_SUB] | o[OP_RSR] | o[OP_RSL];
      e.mask[5] = o[OP_ADD] | o[OP_SUB];
      e.mask[6] = o[OP_IN];
      e.mask[7] = o[OP_OUT];
      e.mask[8] = o[OP_MOVB];
      if (o[OP_MOVA] | o[OP_ADD] | o[OP_SUB] | o[OP_AND] | o[OP_NOT] | o[OP_RSR] |
          o[OP_RSL] | o[OP_IN] | o[OP_MOVC]) e.we_low = 1;
      if ((o[OP_JZ] & !zz) | (o[OP_JC] & !cc)) e.pc_inc = 2;
      e.pc_ld = jt ? 1 : 0;
      e.m01   = o[OP_MOVC] ? 1 + mw : 0;
      e.m10   = o[OP_MOVB] ? 1 + mw : 0;
      if (e.mem) e.cycles += 1 + mw;
      return e;
   endfunction

   // RAM responder: wait for a request, hold off w cycles, then ack one cycle.
   task automatic access(input int w);
      int t = 0;
      while (!(ram_dl || ram_xl)) begin
         @(posedge clk); #1;
         t++;
         if (t > 20) begin
            chk("access_request_timeout", t, 0);
            return;
         end
      end
      repeat (w) begin @(posedge clk); #1; end
      mem_ack = 1'b1;
      @(posedge clk); #1;
      mem_ack = 1'b0;
   endtask

   task automatic issue(input logic [15:0] o, input logic zz, input logic cc,
                        input int fw, input int mw);
      exp_t e;
      bit   is_halt;
      e = model(o, zz, cc, fw, mw);
      is_halt = ($countones(o) == 1) && o[OP_HALT];
      if (!is_halt) m_cnt = (m_cnt + 1) % (1 << CNT_W);
      e.cnt = m_cnt;
      exp_q.push_back(e);
      n_vec++;
      ops = o; z = zz; c = cc; ir = 8'($urandom); run = 1'b1;
      access(fw);
      run = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (e.mem) begin
         z = 1'($urandom); c = 1'($urandom);
         access(mw);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
      chk("scoreboard_drain", exp_q.size(), 0);
   endtask

   initial begin : monitor
      exp_t e;
      bit active;
      int cyc, we_low, pci, pcl, irl, ill, m01, m10;
      logic [8:0] mask;
      logic [CNT_W-1:0] last_cnt;
      logic last_h;
      active = 0; last_cnt = '0; last_h = 1'b0;
      cyc = 0; we_low = 0; pci = 0; pcl = 0; irl = 0; ill = 0; m01 = 0; m10 = 0; mask = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            active = 0; last_cnt = '0; last_h = 1'b0;
            continue;
         end
         if (active && (instr_cnt != last_cnt || (halted && !last_h))) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_retire", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("cycles", cyc, e.cycles);
               chk("strobe_mask", int'(mask), int'(e.mask));
               chk("reg_we_low_cycles", we_low, e.we_low);
               chk("pc_inc_cycles", pci, e.pc_inc);
               chk("pc_ld_cycles", pcl, e.pc_ld);
               chk("ir_ld_cycles", irl, e.ir_ld);
               chk("illegal_pulses", ill, e.illegal);
               chk("madd01_cycles", m01, e.m01);
               chk("madd10_cycles", m10, e.m10);
               chk("instr_cnt", int'(instr_cnt), e.cnt);
            end
            active = 0;
         end else if (active && cyc > 200) begin
            chk("retire_timeout", cyc, 0);
            active = 0;
         end
         last_cnt = instr_cnt;
         last_h   = halted;
         if (!active && ram_dl && madd == 2'b00 && !halted) begin
            active = 1; cyc = 0; we_low = 0; pci = 0; pcl = 0; irl = 0; ill = 0;
            m01 = 0; m10 = 0; mask = '0;
         end
         if (active) begin
            cyc++;
            mask |= {ram_xl, out_en, in_en, zf_en, cf_en, shi_frbus, shi_flbus, shi_fbus, alu_m};
            we_low += int'(!reg_we);
            pci    += int'(pc_inc);
            pcl    += int'(pc_ld);
            irl    += int'(ir_ld);
            ill    += int'(illegal);
            m01    += int'(ram_dl && madd == 2'b01);
            m10    += int'(ram_xl && madd == 2'b10);
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      logic [15:0] o;
      int a, b, r;
      #2;
      chk("rst_reg_we", int'(reg_we), 1);
      chk("rst_ram_dl", int'(ram_dl), 0);
      chk("rst_madd", int'(madd), 0);
      chk("rst_halted", int'(halted), 0);
      chk("rst_pc_inc", int'(pc_inc), 0);
      chk("rst_instr_cnt", int'(instr_cnt), 0);
      for (int i = 0; i < 4; i++) begin
         ir = 8'($urandom); #1;
         chk("reg_ra", int'(reg_ra), int'(ir) % 4);
         chk("reg_wa", int'(reg_wa), (int'(ir) / 4) % 4);
         chk("alu_s", int'(alu_s), int'(ir) / 16);
      end
      @(posedge clk); #1; rst_n = 1'b1;
      @(posedge clk); #1;

      issue(16'(1 << OP_ADD), 0, 0, 0, 0);
      issue(16'(1 << OP_MOVC), 0, 0, 0, 3);
      issue(16'(1 << OP_JZ), 0, 0, 0, 0);
      issue(16'(1 << OP_JZ), 1, 0, 1, 1);
      issue(16'(1 << OP_JC), 0, 1, 0, 2);
      issue(16'(1 << OP_MOVB), 0, 0, 2, 1);
      issue(16'((1 << OP_ADD) | (1 << OP_SUB)), 0, 0, 0, 0);
      issue(16'h0000, 1, 1, 1, 0);

      for (int n = 0; n < 150; n++) begin
         r = $urandom_range(0, 19);
         if (r < 17) o = 16'(1 << $urandom_range(0, 14));
         else if (r == 17) o = '0;
         else begin
            a = $urandom_range(0, 14);
            b = (a + 1 + $urandom_range(0, 13)) % 15;
            o = 16'((1 << a) | (1 << b));
         end
         issue(o, 1'($urandom), 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
      end
      drain();

      issue(16'(1 << OP_HALT), 0, 0, 1, 0);
      run = 1'b1;
      drain();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("halt_hold", int'(halted), 1);
      end
      chk("halt_not_counted", int'(instr_cnt), m_cnt);

      rst_n = 1'b0; exp_q.delete(); m_cnt = 0;
      @(posedge clk); #1; rst_n = 1'b1;
      issue(16'(1 << OP_ADD), 0, 0, 0, 0);
      issue(16'(1 << OP_NOT), 0, 0, 0, 0);
      drain();

      ops = 16'(1 << OP_MOVC); run = 1'b1;
      access(0);
      @(posedge clk); #1;
      chk("mem_madd_movc", int'(madd), 1);
      chk("mem_ram_dl", int'(ram_dl), 1);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("async_rst_ram_dl", int'(ram_dl), 0);
      chk("async_rst_madd", int'(madd), 0);
      chk("async_rst_reg_we", int'(reg_we), 1);
      chk("async_rst_cnt", int'(instr_cnt), 0);
      m_cnt = 0; exp_q.delete();
      @(posedge clk); #1; rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < (1 << CNT_W); i++) issue(16'(1 << OP_NOP), 0, 0, 0, 0);
      drain();
      chk("cnt_wrap", int'(instr_cnt), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
